block_recorder: RTL and testbench

Writer for the beatmap block memory: accepts block descriptors one at a time over a valid/ready handshake, packs each into the 48-bit block word format and writes them to consecutive block-memory lines starting at line 1. On finish it writes a header word holding the block count to line 0. Sits between the beatmap capture/editor logic and the write port of the block BRAM that `block_loader` later reads.

---
 rtl/block_recorder_pkg.sv | 58 +++++
 rtl/block_recorder_if.sv | 35 +++
 rtl/block_recorder.sv | 122 ++++++++++++
 tb/tb_block_recorder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/block_recorder_pkg.sv
// Shared definitions for the beatmap block memory: word layout, enums and the packer.
// Also used by block_loader to unpack words written here.
package block_recorder_pkg;

    localparam int MAX_BLOCK_SIZE = 256;
    localparam int WORD_W         = 48;
    localparam int COORD_W        = 12;
    localparam int TIME_W         = 18;
    localparam int DIR_W          = 3;

    localparam int X_HI      = 45;
    localparam int X_LO      = 34;
    localparam int Y_HI      = 33;
    localparam int Y_LO      = 22;
    localparam int T_HI      = 21;
    localparam int T_LO      = 4;
    localparam int COLOR_BIT = 3;
    localparam int DIR_HI    = 2;
    localparam int DIR_LO    = 0;

    typedef enum logic [DIR_W-1:0] {
        DIR_UP    = 3'd0,
        DIR_RIGHT = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_ANY   = 3'd4
    } direction_e;

    typedef enum logic {
        COLOR_BLUE = 1'b0,
        COLOR_RED  = 1'b1
    } block_color_enum;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECORD,
        ST_FINALIZE,
        ST_DONE
    } rec_state_e;

    function automatic logic [WORD_W-1:0] pack_block(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [TIME_W-1:0]  t,
        input logic               color,
        input logic [DIR_W-1:0]   dir
    );
        logic [WORD_W-1:0] w;
        w                 = '0;
        w[X_HI:X_LO]      = x;
        w[Y_HI:Y_LO]      = y;
        w[T_HI:T_LO]      = t;
        w[COLOR_BIT]      = color;
        w[DIR_HI:DIR_LO]  = dir;
        return w;
    endfunction

endpackage

// File: rtl/block_recorder_if.sv
// Descriptor handshake, block-memory write port and session status of block_recorder.
interface block_recorder_if #(
    parameter int ADDR_W = $clog2(block_recorder_pkg::MAX_BLOCK_SIZE) + 1
);
    logic              start_in;
    logic              finish_in;
    logic              valid_in;
    logic              ready_out;
    logic [11:0]       block_x_in;
    logic [11:0]       block_y_in;
    logic [17:0]       block_time_in;
    logic              block_color_in;
    logic [2:0]        block_direction_in;
    logic [ADDR_W-1:0] ram_addr_out;
    logic [47:0]       ram_din_out;
    logic              ram_we_out;
    logic [ADDR_W-1:0] block_count_out;
    logic              full_out;
    logic              error_out;
    logic              done_out;

    modport master (
        output start_in, finish_in, valid_in,
        output block_x_in, block_y_in, block_time_in, block_color_in, block_direction_in,
        input  ready_out, ram_addr_out, ram_din_out, ram_we_out,
        input  block_count_out, full_out, error_out, done_out
    );

    modport slave (
        input  start_in, finish_in, valid_in,
        input  block_x_in, block_y_in, block_time_in, block_color_in, block_direction_in,
        output ready_out, ram_addr_out, ram_din_out, ram_we_out,
        output block_count_out, full_out, error_out, done_out
    );
endinterface

// File: rtl/block_recorder.sv
// Packs block descriptors into 48-bit words for block memory lines 1..N, then writes
// the block count header to line 0.
//   state    | meaning
//   IDLE     | waiting for the first start pulse
//   RECORD   | accepting descriptors, one per cycle
//   FINALIZE | header write registered on leaving this state
//   DONE     | session complete, done_out raised one cycle after entry
module block_recorder #(
    parameter int MAX_BLOCK_SIZE = block_recorder_pkg::MAX_BLOCK_SIZE,
    parameter int ADDR_W         = $clog2(MAX_BLOCK_SIZE) + 1
) (
    input logic             clk_in,
    input logic             rst_in,
    block_recorder_if.slave bus
);
    import block_recorder_pkg::*;

    localparam logic [ADDR_W-1:0] COUNT_MAX = ADDR_W'(MAX_BLOCK_SIZE);

    rec_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [TIME_W-1:0]   last_time_q, last_time_d;
    logic                error_q, error_d;
    logic                done_q, done_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   din_q, din_d;
    logic                full;
    logic                ready;
    logic                accept;
    logic                legal;

    assign full   = (count_q == COUNT_MAX);
    assign ready  = (state_q == ST_RECORD) && !full;
    // A start pulse restarts the session, so a descriptor offered alongside it is dropped.
    assign accept = bus.valid_in && ready && !bus.start_in;
    assign legal  = (bus.block_time_in >= last_time_q) && (bus.block_direction_in <= DIR_ANY);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        last_time_d = last_time_q;
        error_d     = error_q;
        done_d      = done_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;

        if (bus.start_in && (state_q != ST_FINALIZE)) begin
            state_d     = ST_RECORD;
            count_d     = '0;
            last_time_d = '0;
            error_d     = 1'b0;
            done_d      = 1'b0;
        end else begin
            case (state_q)
                ST_RECORD: begin
                    if (accept) begin
                        if (legal) begin
                            we_d        = 1'b1;
                            addr_d      = count_q + 1'b1;
                            din_d       = pack_block(bus.block_x_in, bus.block_y_in,
                                                     bus.block_time_in, bus.block_color_in,
                                                     bus.block_direction_in);
                            count_d     = count_q + 1'b1;
                            last_time_d = bus.block_time_in;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                    if (bus.finish_in) begin
                        state_d = ST_FINALIZE;
                    end
                end
                ST_FINALIZE: begin
                    we_d    = 1'b1;
                    addr_d  = '0;
                    din_d   = WORD_W'(count_q);
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            last_time_q <= '0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            last_time_q <= last_time_d;
            error_q     <= error_d;
            done_q      <= done_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
        end
    end

    assign bus.ready_out       = ready;
    assign bus.full_out        = full;
    assign bus.block_count_out = count_q;
    assign bus.error_out       = error_q;
    assign bus.done_out        = done_q;
    assign bus.ram_we_out      = we_q;
    assign bus.ram_addr_out    = addr_q;
    assign bus.ram_din_out     = din_q;

endmodule

// File: tb/tb_block_recorder.sv
// Scoreboard bench for block_recorder: a session-level model queues expected memory
// writes, a monitor checks every write the recorder presents.
module tb_block_recorder;

    localparam int MAXB   = 256;
    localparam int ADDR_W = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;

    block_recorder_if #(.ADDR_W(ADDR_W)) bus();

    block_recorder #(.MAX_BLOCK_SIZE(MAXB), .ADDR_W(ADDR_W)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          exp_addr[$];
    logic [47:0] exp_data[$];

    // session model
    bit recording = 0;
    int cnt       = 0;
    int last_t    = 0;
    bit err       = 0;
    int dstage    = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] model_word(int x, int y, int t, int c, int d);
        return 48'(x) * 48'h4_0000_0000 + 48'(y) * 48'h40_0000 + 48'(t) * 48'd16
             + 48'(c) * 48'd8 + 48'(d);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (bus.ram_we_out === 1'b1) begin
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                             bus.ram_addr_out, bus.ram_din_out);
                end else begin
                    int          a;
                    logic [47:0] w;
                    a = exp_addr.pop_front();
                    w = exp_data.pop_front();
                    chk("write_addr", 64'(bus.ram_addr_out), 64'(a));
                    chk("write_data", 64'(bus.ram_din_out), 64'(w));
                end
            end
        end
    end

    task automatic step(input bit s, input bit f, input bit v,
                        input int x, input int y, input int t, input int c, input int d);
        bus.start_in           = s;
        bus.finish_in          = f;
        bus.valid_in           = v;
        bus.block_x_in         = 12'(x);
        bus.block_y_in         = 12'(y);
        bus.block_time_in      = 18'(t);
        bus.block_color_in     = 1'(c);
        bus.block_direction_in = 3'(d);
        chk("ready", 64'(bus.ready_out), 64'(recording && cnt < MAXB));

        if (s) begin
            recording = 1; cnt = 0; last_t = 0; err = 0; dstage = -1;
        end else if (recording) begin
            if (v && cnt < MAXB) begin
                if (t >= last_t && d <= 4) begin
                    exp_addr.push_back(cnt + 1);
                    exp_data.push_back(model_word(x, y, t, c, d));
                    cnt++;
                    last_t = t;
                end else begin
                    err = 1;
                end
            end
            if (f) begin
                recording = 0;
                exp_addr.push_back(0);
                exp_data.push_back(48'(cnt));
                dstage = 0;
            end
        end else if (dstage >= 0) begin
            dstage++;
        end

        @(posedge clk);
        #1;
        bus.start_in  = 1'b0;
        bus.finish_in = 1'b0;
        bus.valid_in  = 1'b0;
        chk("count", 64'(bus.block_count_out), 64'(cnt));
        chk("error", 64'(bus.error_out), 64'(err));
        chk("full",  64'(bus.full_out), 64'(cnt == MAXB));
        chk("done",  64'(bus.done_out), 64'(dstage >= 2));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic blk(input int x, input int y, input int t, input int c, input int d);
        step(0, 0, 1, x, y, t, c, d);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(bus.ready_out), 0);
        chk({tag, "_we"},    64'(bus.ram_we_out), 0);
        chk({tag, "_full"},  64'(bus.full_out), 0);
        chk({tag, "_err"},   64'(bus.error_out), 0);
        chk({tag, "_done"},  64'(bus.done_out), 0);
        chk({tag, "_addr"},  64'(bus.ram_addr_out), 0);
        chk({tag, "_din"},   64'(bus.ram_din_out), 0);
        chk({tag, "_count"}, 64'(bus.block_count_out), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gen_t;
        bus.start_in = 0; bus.finish_in = 0; bus.valid_in = 0;
        bus.block_x_in = 0; bus.block_y_in = 0; bus.block_time_in = 0;
        bus.block_color_in = 0; bus.block_direction_in = 0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst = 1'b0;

        step(0, 1, 0, 0, 0, 0, 0, 0);           // finish in IDLE is ignored

        // three-block session
        step(1, 0, 0, 0, 0, 0, 0, 0);
        blk(100, 200, 10, 1, 0);
        blk(5, 6, 10, 0, 4);
        blk(7, 8, 50, 1, 3);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(3);
        step(0, 1, 0, 0, 0, 0, 0, 0);           // finish in DONE is ignored

        // out-of-order time
        step(1, 0, 0, 0, 0, 0, 0, 0);
        blk(1, 1, 50, 0, 1);
        blk(2, 2, 40, 1, 2);
        blk(3, 3, 60, 0, 2);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(3);

        // illegal direction, then restart clears error and count
        step(1, 0, 0, 0, 0, 0, 0, 0);
        blk(9, 9, 5, 0, 0);
        blk(9, 9, 7, 1, 6);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        blk(4, 4, 3, 1, 2);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(3);

        // finish together with the second accept
        step(1, 0, 0, 0, 0, 0, 0, 0);
        blk(11, 12, 1, 0, 1);
        step(0, 1, 1, 13, 14, 2, 1, 3);
        idle(3);

        // start and finish together: start wins
        step(1, 1, 0, 0, 0, 0, 0, 0);
        blk(20, 21, 0, 1, 4);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(3);

        // fill to capacity with valid held high
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < MAXB; i++)
            blk($urandom_range(0, 4095), $urandom_range(0, 4095), i * 3,
                $urandom_range(0, 1), $urandom_range(0, 4));
        blk(1, 2, 5000, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(3);

        // randomized sessions
        for (int s = 0; s < 8; s++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0);
            gen_t = $urandom_range(0, 100);
            for (int i = 0; i < int'($urandom_range(5, 40)); i++) begin
                int t, d;
                if ($urandom_range(0, 5) == 0 && gen_t >= 3) t = gen_t - $urandom_range(1, 3);
                else begin gen_t += $urandom_range(0, 4); t = gen_t; end
                d = ($urandom_range(0, 6) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
                step(0, 0, ($urandom_range(0, 3) != 0), $urandom_range(0, 4095),
                     $urandom_range(0, 4095), t, $urandom_range(0, 1), d);
            end
            gen_t += 1;
            step(0, 1, $urandom_range(0, 1), $urandom_range(0, 4095), $urandom_range(0, 4095),
                 gen_t, $urandom_range(0, 1), $urandom_range(0, 4));
            idle(3);
        end

        // reset right after an accept cancels the pending write
        step(1, 0, 0, 0, 0, 0, 0, 0);
        blk(30, 31, 8, 1, 1);
        rst = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        recording = 0; cnt = 0; last_t = 0; err = 0; dstage = -1;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1;
        chk("midrst_we_held", 64'(bus.ram_we_out), 0);
        rst = 1'b0;
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        blk(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(3);

        chk("pending_writes", 64'(exp_addr.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
